// File: rtl/usb_serial_loopback_fifo_if.sv
// Byte-stream handshake between usb_serial_top and the loopback FIFO.
// The FIFO uses the slave modport: it takes recv_* and drives send_*.
interface usb_serial_loopback_fifo_if;
   logic [7:0] recv_data;
   logic       recv_valid;
   logic [7:0] send_data;
   logic       send_valid;
   logic       send_ready;

   modport master (
      output recv_data, recv_valid, send_ready,
      input  send_data, send_valid
   );

   modport slave (
      input  recv_data, recv_valid, send_ready,
      output send_data, send_valid
   );
endinterface

// File: rtl/usb_serial_loopback_fifo.sv
// Case-transforming first-word-fall-through loopback FIFO with saturating overflow accounting.
// Optional USB_LOOPBACK_CRLF_EN: a received CR is stored as the pair CR, LF in a single cycle.
module usb_serial_loopback_fifo #(
   parameter int DEPTH_LOG2 = 6,
   parameter int DROP_W     = 16
) (
   input  logic                   clk,
   input  logic                   rstn,
   usb_serial_loopback_fifo_if.slave bus,
   input  logic [1:0]             mode,
   input  logic                   ovf_clr,
   output logic [DEPTH_LOG2:0]    level,
   output logic [DROP_W-1:0]      drop_cnt,
   output logic                   overflow
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int LW    = DEPTH_LOG2 + 2;

   typedef logic [DEPTH_LOG2-1:0] ptr_t;

   typedef enum logic [1:0] {
      MODE_PASS     = 2'd0,
      MODE_TO_UPPER = 2'd1,
      MODE_TO_LOWER = 2'd2,
      MODE_TOGGLE   = 2'd3
   } mode_e;

   function automatic logic [7:0] f_transform(input mode_e m, input logic [7:0] b);
      logic is_lower;
      logic is_upper;
      is_lower    = (b >= 8'h61) && (b <= 8'h7A);
      is_upper    = (b >= 8'h41) && (b <= 8'h5A);
      f_transform = b;
      case (m)
         MODE_TO_UPPER: if (is_lower) f_transform = b - 8'h20;
         MODE_TO_LOWER: if (is_upper) f_transform = b + 8'h20;
         MODE_TOGGLE:   if (is_lower || is_upper) f_transform = b ^ 8'h20;
         default:       f_transform = b;
      endcase
   endfunction

   logic [7:0]          r_mem [DEPTH];
   ptr_t                r_wr_ptr;
   ptr_t                r_rd_ptr;
   logic [DEPTH_LOG2:0] r_level;
   logic                r_send_valid;
   logic [7:0]          r_send_data;
   logic [DROP_W-1:0]   r_drop_cnt;
   logic                r_overflow;

   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic                w_two;
   logic [7:0]          w_byte;
   logic [7:0]          w_head_next;
   logic [LW-1:0]       w_need;
   logic [LW-1:0]       w_free;
   logic [LW-1:0]       w_level_next;
   ptr_t                w_rd_next;
   ptr_t                w_wr_next;

   // NOTE: every signal gets its value at the top of the block so no path can infer a latch.
   always_comb begin
      w_byte = f_transform(mode_e'(mode), bus.recv_data);
`ifdef USB_LOOPBACK_CRLF_EN
      w_two  = (w_byte == 8'h0D);
`else
      w_two  = 1'b0;
`endif
      w_pop        = r_send_valid & bus.send_ready;
      w_need       = w_two ? LW'(2) : LW'(1);
      // A pop in the same cycle frees a slot for the incoming write.
      w_free       = LW'(DEPTH) - LW'(r_level) + LW'(w_pop);
      w_push       = bus.recv_valid && (w_free >= w_need);
      w_drop       = bus.recv_valid && !w_push;
      w_level_next = LW'(r_level) + (w_push ? w_need : '0) - LW'(w_pop);
      w_rd_next    = r_rd_ptr + ptr_t'(w_pop);
      w_wr_next    = r_wr_ptr + (w_push ? ptr_t'(w_need) : '0);
      // The new head is the byte being written only when the FIFO drains to empty this cycle.
      w_head_next  = r_mem[w_rd_next];
      if (w_push && (r_wr_ptr == w_rd_next)) w_head_next = w_byte;
   end

   // NOTE: byte storage carries no reset; the pointers and level alone define which entries are live.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_byte;
`ifdef USB_LOOPBACK_CRLF_EN
         if (w_two) r_mem[r_wr_ptr + ptr_t'(1)] <= 8'h0A;
`endif
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_send_valid <= 1'b0;
         r_send_data  <= 8'h00;
         r_drop_cnt   <= '0;
         r_overflow   <= 1'b0;
      end else begin
         r_wr_ptr     <= w_wr_next;
         r_rd_ptr     <= w_rd_next;
         r_level      <= w_level_next[DEPTH_LOG2:0];
         r_send_valid <= (w_level_next != '0);
         r_send_data  <= w_head_next;
         // A drop takes priority over a clear issued in the same cycle.
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (ovf_clr)                r_drop_cnt <= DROP_W'(1);
            else if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_W'(1);
         end else if (ovf_clr) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
         end
      end
   end

   assign bus.send_data  = r_send_data;
   assign bus.send_valid = r_send_valid;
   assign level          = r_level;
   assign drop_cnt       = r_drop_cnt;
   assign overflow       = r_overflow;

endmodule

// File: tb/tb_usb_serial_loopback_fifo.sv
// Randomized and directed bench for usb_serial_loopback_fifo against a queue-based reference model.
// Built with DEPTH_LOG2=2 and a 4-bit drop counter so full and saturation corners are cheap to reach.
module tb_usb_serial_loopback_fifo;

   localparam int DL2   = 2;
   localparam int DEPTH = 1 << DL2;
   localparam int DW    = 4;
   localparam int DMAX  = (1 << DW) - 1;
`ifdef USB_LOOPBACK_CRLF_EN
   localparam bit CRLF  = 1'b1;
`else
   localparam bit CRLF  = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [1:0]    mode;
   logic          ovf_clr;
   logic [DL2:0]  level;
   logic [DW-1:0] drop_cnt;
   logic          overflow;

   usb_serial_loopback_fifo_if bus ();

   usb_serial_loopback_fifo #(
      .DEPTH_LOG2 (DL2),
      .DROP_W     (DW)
   ) dut (
      .clk      (clk),
      .rstn     (rstn),
      .bus      (bus),
      .mode     (mode),
      .ovf_clr  (ovf_clr),
      .level    (level),
      .drop_cnt (drop_cnt),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] q[$];
   int         m_drops  = 0;
   bit         m_ovf    = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_xform(input logic [1:0] m, input logic [7:0] b);
      bit lo = (b >= 8'h61 && b <= 8'h7A);
      bit up = (b >= 8'h41 && b <= 8'h5A);
      if (m == 2'd1 && lo)         return b - 8'h20;
      if (m == 2'd2 && up)         return b + 8'h20;
      if (m == 2'd3 && (lo || up)) return b ^ 8'h20;
      return b;
   endfunction

   task automatic check_outputs(input string tag);
      check({tag, "_valid"}, 32'(bus.send_valid), 32'(q.size() != 0));
      check({tag, "_level"}, 32'(level), 32'(q.size()));
      if (q.size() != 0) check({tag, "_data"}, 32'(bus.send_data), 32'(q[0]));
      check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drops));
      check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
   endtask

   // One clock: drive inputs, compare pre-edge outputs, advance the model, settle past the edge.
   task automatic cycle(input bit rv, input logic [7:0] d, input logic [1:0] m, input bit sr, input bit clr);
      bit         pop;
      int         free;
      logic [7:0] items[$];
      logic [7:0] b;
      bus.recv_valid = rv;
      bus.recv_data  = d;
      bus.send_ready = sr;
      mode           = m;
      ovf_clr        = clr;
      check_outputs("cyc");
      pop  = sr && (q.size() != 0);
      free = DEPTH - q.size() + int'(pop);
      if (rv) begin
         b = ref_xform(m, d);
         items.push_back(b);
         if (CRLF && b == 8'h0D) items.push_back(8'h0A);
      end
      if (rv && items.size() > free) begin
         items.delete();
         m_ovf   = 1'b1;
         m_drops = clr ? 1 : ((m_drops < DMAX) ? m_drops + 1 : DMAX);
      end else if (clr) begin
         m_ovf   = 1'b0;
         m_drops = 0;
      end
      @(posedge clk);
      #1;
      if (pop) void'(q.pop_front());
      foreach (items[i]) q.push_back(items[i]);
      bus.recv_valid = 1'b0;
      ovf_clr        = 1'b0;
   endtask

   task automatic idle(input bit sr);
      cycle(1'b0, 8'h00, 2'd0, sr, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.recv_valid = 1'b0;
      bus.recv_data  = 8'h00;
      bus.send_ready = 1'b0;
      mode           = 2'd0;
      ovf_clr        = 1'b0;
      #12;
      check("rst_valid", 32'(bus.send_valid), 32'h0);
      check("rst_data", 32'(bus.send_data), 32'h0);
      check("rst_level", 32'(level), 32'h0);
      check("rst_drop", 32'(drop_cnt), 32'h0);
      check("rst_ovf", 32'(overflow), 32'h0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // Upper-casing while streaming: each byte appears one cycle after its receive pulse.
      cycle(1'b1, 8'h61, 2'd1, 1'b1, 1'b0);
      check("t1_a", 32'(bus.send_data), 32'h41);
      cycle(1'b1, 8'h5A, 2'd1, 1'b1, 1'b0);
      check("t1_Z", 32'(bus.send_data), 32'h5A);
      cycle(1'b1, 8'h7B, 2'd1, 1'b1, 1'b0);
      check("t1_brace", 32'(bus.send_data), 32'h7B);
      idle(1'b1);
      check("t1_empty", 32'(bus.send_valid), 32'h0);

      // Toggle mode with backpressure, then drain back to back.
      cycle(1'b1, 8'h61, 2'd3, 1'b0, 1'b0);
      cycle(1'b1, 8'h42, 2'd3, 1'b0, 1'b0);
      idle(1'b0);
      check("t2_level", 32'(level), 32'h2);
      check("t2_hold", 32'(bus.send_data), 32'h41);
      idle(1'b1);
      check("t2_second", 32'(bus.send_data), 32'h62);
      idle(1'b1);
      check("t2_level0", 32'(level), 32'h0);
      check("t2_valid0", 32'(bus.send_valid), 32'h0);

      // Overflow: six pushes into a four-entry FIFO.
      for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h30 + i), 2'd0, 1'b0, 1'b0);
      check("t3_level", 32'(level), 32'h4);
      check("t3_drop", 32'(drop_cnt), 32'h2);
      check("t3_ovf", 32'(overflow), 32'h1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      cycle(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
      check("t3_clr_drop", 32'(drop_cnt), 32'h0);
      check("t3_clr_ovf", 32'(overflow), 32'h0);

      // Push and pop while full: write accepted, level stays at DEPTH.
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 2'd0, 1'b0, 1'b0);
      cycle(1'b1, 8'h99, 2'd0, 1'b1, 1'b0);
      check("t4_level", 32'(level), 32'h4);
      check("t4_drop", 32'(drop_cnt), 32'h0);
      for (int i = 0; i < 4; i++) idle(1'b1);
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hA0 + 16 * r + i), 2'd0, 1'b0, 1'b0);
         for (int i = 0; i < 4; i++) idle(1'b1);
      end

      // Drop counter saturation, then a clear coinciding with a drop.
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h20 + i), 2'd0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) cycle(1'b1, 8'h55, 2'd0, 1'b0, 1'b0);
      check("sat_drop", 32'(drop_cnt), 32'(DMAX));
      cycle(1'b1, 8'h56, 2'd0, 1'b0, 1'b1);
      check("clr_vs_drop_cnt", 32'(drop_cnt), 32'h1);
      check("clr_vs_drop_ovf", 32'(overflow), 32'h1);
      for (int i = 0; i < 4; i++) idle(1'b1);
      cycle(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

      // Asynchronous reset in the middle of a drain.
      for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'hC0 + i), 2'd0, 1'b0, 1'b0);
      idle(1'b1);
      check("t5_pre_level", 32'(level), 32'h3);
      bus.send_ready = 1'b1;
      #3 rstn = 1'b0;
      #1;
      check("t5_rst_valid", 32'(bus.send_valid), 32'h0);
      check("t5_rst_level", 32'(level), 32'h0);
      q.delete();
      m_drops = 0;
      m_ovf   = 1'b0;
      #2 rstn = 1'b1;
      @(posedge clk);
      #1;
      cycle(1'b1, 8'h77, 2'd0, 1'b0, 1'b0);
      check("t5_alone_level", 32'(level), 32'h1);
      check("t5_alone_data", 32'(bus.send_data), 32'h77);
      idle(1'b1);
      check("t5_alone_empty", 32'(bus.send_valid), 32'h0);

`ifdef USB_LOOPBACK_CRLF_EN
      cycle(1'b1, 8'h0D, 2'd0, 1'b0, 1'b0);
      check("t6_level", 32'(level), 32'h2);
      check("t6_cr", 32'(bus.send_data), 32'h0D);
      idle(1'b1);
      check("t6_lf", 32'(bus.send_data), 32'h0A);
      idle(1'b1);
      for (int i = 0; i < DEPTH - 1; i++) cycle(1'b1, 8'(8'h30 + i), 2'd0, 1'b0, 1'b0);
      cycle(1'b1, 8'h0D, 2'd0, 1'b0, 1'b0);
      check("t6_full_level", 32'(level), 32'(DEPTH - 1));
      check("t6_full_drop", 32'(drop_cnt), 32'h1);
      for (int i = 0; i < DEPTH; i++) idle(1'b1);
      cycle(1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
`endif

      // Randomized traffic with varying drain pressure.
      for (int s = 0; s < 12; s++) begin
         int sr_pct = (s % 3 == 0) ? 20 : ((s % 3 == 1) ? 55 : 90);
         for (int i = 0; i < 200; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 4))
               0:       d = 8'($urandom_range(8'h41, 8'h5A));
               1:       d = 8'($urandom_range(8'h61, 8'h7A));
               2:       d = 8'h0D;
               3:       case ($urandom_range(0, 3))
                           0: d = 8'h40;
                           1: d = 8'h5B;
                           2: d = 8'h60;
                           default: d = 8'h7B;
                        endcase
               default: d = 8'($urandom);
            endcase
            cycle($urandom_range(0, 99) < 70, d, 2'($urandom_range(0, 3)),
                  $urandom_range(0, 99) < sr_pct, $urandom_range(0, 31) == 0);
         end
      end
      for (int i = 0; i < 2 * DEPTH; i++) idle(1'b1);
      check("final_empty", 32'(level), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
